raster_sched: RTL and testbench

//  Triangle job scheduler in front of the Pineda edge-function fragment generator.

---
 rtl/raster_sched.sv | 128 ++++++++++++
 tb/tb_raster_sched.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/raster_sched.sv
// Triangle job scheduler: queues set-up triangles, issues them one at a time to the
// edge-function fragment generator, forwards tagged fragments and emits one completion per triangle.
module raster_sched #(
    parameter int TQ_DEPTH = 4,
    parameter int ID_W     = 8,
    parameter int CNT_W    = 24,
    parameter int TIMEOUT  = 1 << 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tri_val,
    output logic              tri_rdy,
    input  logic [ID_W-1:0]   tri_id,
    input  logic [415:0]      tri_desc,
    output logic              ras_start,
    output logic [415:0]      ras_desc,
    input  logic              ras_ready,
    input  logic              ras_done,
    input  logic              ras_frag_val,
    output logic              ras_pop_frag,
    output logic              frag_out_val,
    input  logic              frag_out_rdy,
    output logic [ID_W-1:0]   frag_out_id,
    output logic              cmp_val,
    input  logic              cmp_rdy,
    output logic [ID_W-1:0]   cmp_id,
    output logic [CNT_W-1:0]  cmp_cnt,
    output logic              err_timeout,
    output logic [1:0]        state_dbg
);
    // Handshakes: a transfer happens on the rising edge where valid && ready are both 1;
    // valid never waits on ready, and payload is held stable while valid && !ready.

    localparam int PW   = $clog2(TQ_DEPTH);
    localparam int WD_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, CHECK, RUN, RETIRE} state_t;

    state_t            state;
    logic [PW:0]       wr_ptr;
    logic [PW:0]       rd_ptr;
    logic [ID_W-1:0]   id_mem   [TQ_DEPTH];
    logic [415:0]      desc_mem [TQ_DEPTH];
    logic [CNT_W-1:0]  cnt;
    logic [WD_W-1:0]   wdog;
    logic              empty;
    logic              full;
    logic              push;
    logic              degenerate;
    logic [31:0]       ymin, ymax, xmin, xmax;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign push  = tri_val && !full;

    assign tri_rdy      = !full;
    assign ras_desc     = desc_mem[rd_ptr[PW-1:0]];
    assign frag_out_id  = id_mem[rd_ptr[PW-1:0]];
    assign cmp_id       = id_mem[rd_ptr[PW-1:0]];
    assign cmp_cnt      = cnt;
    assign cmp_val      = (state == RETIRE);
    assign frag_out_val = (state == RUN) && ras_frag_val;
    assign ras_pop_frag = (state == RUN) && ras_frag_val && frag_out_rdy;
    assign state_dbg    = state;

    assign ymin = ras_desc[415:384];
    assign ymax = ras_desc[383:352];
    assign xmin = ras_desc[351:320];
    assign xmax = ras_desc[319:288];
    assign degenerate = (ymin > ymax) || (xmin > xmax);

    always_ff @(posedge clk) begin
        if (push) begin
            id_mem[wr_ptr[PW-1:0]]   <= tri_id;
            desc_mem[wr_ptr[PW-1:0]] <= tri_desc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
        end else if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
        end
    end

    // The head entry stays in the queue until its completion is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            rd_ptr      <= '0;
            ras_start   <= 1'b0;
            cnt         <= '0;
            wdog        <= '0;
            err_timeout <= 1'b0;
        end else begin
            ras_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (!empty) state <= CHECK;
                end
                CHECK: begin
                    if (degenerate) begin
                        state <= RETIRE;
                    end else if (ras_ready) begin
                        ras_start <= 1'b1;
                        wdog      <= '0;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    if (ras_pop_frag && (cnt != {CNT_W{1'b1}})) cnt <= cnt + 1'b1;
                    if (wdog != WD_W'(TIMEOUT)) wdog <= wdog + 1'b1;
                    if (wdog == WD_W'(TIMEOUT - 1)) err_timeout <= 1'b1;
                    if (ras_done) state <= RETIRE;
                end
                RETIRE: begin
                    if (cmp_rdy) begin
                        rd_ptr <= rd_ptr + 1'b1;
                        cnt    <= '0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_raster_sched.sv
// Directed bench for raster_sched: a behavioural generator model, a driver, and a monitor
// that checks fragments, completions and issued descriptors against expected queues.
module tb_raster_sched;
    localparam int ID_W  = 8;
    localparam int CNT_W = 24;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              tri_val;
    logic              tri_rdy;
    logic [ID_W-1:0]   tri_id;
    logic [415:0]      tri_desc;
    logic              ras_start;
    logic [415:0]      ras_desc;
    logic              ras_ready;
    logic              ras_done;
    logic              ras_frag_val;
    logic              ras_pop_frag;
    logic              frag_out_val;
    logic              frag_out_rdy;
    logic [ID_W-1:0]   frag_out_id;
    logic              cmp_val;
    logic              cmp_rdy;
    logic [ID_W-1:0]   cmp_id;
    logic [CNT_W-1:0]  cmp_cnt;
    logic              err_timeout;
    logic [1:0]        state_dbg;

    always #5 clk = ~clk;

    raster_sched #(.TQ_DEPTH(4), .ID_W(ID_W), .CNT_W(CNT_W), .TIMEOUT(64)) dut (
        .clk(clk), .rst(rst),
        .tri_val(tri_val), .tri_rdy(tri_rdy), .tri_id(tri_id), .tri_desc(tri_desc),
        .ras_start(ras_start), .ras_desc(ras_desc), .ras_ready(ras_ready),
        .ras_done(ras_done), .ras_frag_val(ras_frag_val), .ras_pop_frag(ras_pop_frag),
        .frag_out_val(frag_out_val), .frag_out_rdy(frag_out_rdy), .frag_out_id(frag_out_id),
        .cmp_val(cmp_val), .cmp_rdy(cmp_rdy), .cmp_id(cmp_id), .cmp_cnt(cmp_cnt),
        .err_timeout(err_timeout), .state_dbg(state_dbg)
    );

    int n_vec   = 0;
    int n_err   = 0;
    int n_start = 0;
    logic [ID_W-1:0]       exp_frag_q[$];
    logic [ID_W+CNT_W-1:0] exp_cmp_q[$];
    logic [415:0]          exp_desc_q[$];
    bit gen_hold = 1'b0;
    bit gen_hang = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [415:0] mk_desc(input logic [31:0] xmin, input logic [31:0] xmax,
                                             input logic [31:0] ymin, input logic [31:0] ymax);
        logic [31:0] w;
        w = 32'hA5A5_0000 ^ {xmin[15:0], ymax[15:0]};
        return {ymin, ymax, xmin, xmax, {9{w}}};
    endfunction

    // Generator model: ready drops after start, frags available at once, done then ready.
    initial begin
        int gen_st;
        int remaining;
        logic start_s, pop_s;
        logic [31:0] gx0, gx1, gy0, gy1;
        gen_st = 0; remaining = 0;
        ras_ready = 1'b1; ras_done = 1'b0; ras_frag_val = 1'b0;
        forever begin
            @(negedge clk);
            start_s = ras_start;
            pop_s   = ras_pop_frag;
            @(posedge clk); #1;
            if (rst) begin
                gen_st = 0; remaining = 0;
                ras_ready = 1'b1; ras_done = 1'b0; ras_frag_val = 1'b0;
            end else begin
                case (gen_st)
                    0: begin
                        ras_ready = !gen_hold;
                        if (start_s) begin
                            gy0 = ras_desc[415:384]; gy1 = ras_desc[383:352];
                            gx0 = ras_desc[351:320]; gx1 = ras_desc[319:288];
                            remaining = int'((gx1 - gx0 + 1) * (gy1 - gy0 + 1));
                            ras_ready = 1'b0;
                            ras_frag_val = 1'b1;
                            gen_st = gen_hang ? 3 : 1;
                        end
                    end
                    1: begin
                        if (pop_s) remaining--;
                        if (remaining == 0) begin
                            ras_frag_val = 1'b0;
                            ras_done = 1'b1;
                            gen_st = 2;
                        end
                    end
                    2: begin
                        ras_done = 1'b0;
                        ras_ready = !gen_hold;
                        gen_st = 0;
                    end
                    default: begin
                        ras_ready = 1'b0;
                        ras_frag_val = 1'b1;
                    end
                endcase
            end
        end
    end

    // Monitor: sampled on the falling edge, transfers complete on the next rising edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (ras_start) begin
                n_start++;
                if (exp_desc_q.size() == 0) chk("start_unexpected", 1, 0);
                else begin
                    logic [415:0] d;
                    d = exp_desc_q.pop_front();
                    n_vec++;
                    if (ras_desc !== d) begin
                        n_err++;
                        $display("FAIL ras_desc: got %0h expected %0h", ras_desc[415:288], d[415:288]);
                    end
                end
            end
            if (frag_out_val) chk("pop_frag", ras_pop_frag, frag_out_rdy);
            if (frag_out_val && frag_out_rdy) begin
                if (exp_frag_q.size() == 0) chk("frag_unexpected", 1, 0);
                else chk("frag_id", frag_out_id, exp_frag_q.pop_front());
            end
            if (cmp_val && cmp_rdy) begin
                if (exp_cmp_q.size() == 0) chk("cmp_unexpected", 1, 0);
                else chk("cmp_rec", {cmp_id, cmp_cnt}, exp_cmp_q.pop_front());
            end
        end
    end

    task automatic push_tri(input logic [ID_W-1:0] id, input int xmin, input int xmax,
                            input int ymin, input int ymax, input int n, input bit with_cmp,
                            input bit will_start);
        int b;
        tri_val  = 1'b1;
        tri_id   = id;
        tri_desc = mk_desc(xmin, xmax, ymin, ymax);
        b = 0;
        while (!tri_rdy && b < 300) begin
            @(posedge clk); #1;
            b++;
        end
        if (b >= 300) begin
            chk("push_timeout", 0, 1);
            tri_val = 1'b0;
            return;
        end
        if (will_start) exp_desc_q.push_back(tri_desc);
        repeat (n) exp_frag_q.push_back(id);
        if (with_cmp) exp_cmp_q.push_back({id, CNT_W'(n)});
        @(posedge clk); #1;
        tri_val = 1'b0;
    endtask

    task automatic wait_drain();
        int b;
        b = 0;
        while ((exp_cmp_q.size() != 0 || exp_frag_q.size() != 0 || state_dbg != 2'd0) && b < 1000) begin
            @(posedge clk); #1;
            b++;
        end
        chk("drain_done", b < 1000, 1);
    endtask

    initial begin
        int k, s0, b;
        tri_val = 1'b0; tri_id = '0; tri_desc = '0;
        frag_out_rdy = 1'b1; cmp_rdy = 1'b1;
        #1;
        chk("rst_ras_start", ras_start, 0);
        chk("rst_cmp_val", cmp_val, 0);
        chk("rst_frag_val", frag_out_val, 0);
        chk("rst_err", err_timeout, 0);
        chk("rst_cnt", cmp_cnt, 0);
        chk("rst_state", state_dbg, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("tri_rdy_after_rst", tri_rdy, 1);

        // One 4x2 box, every pixel inside: 8 fragments, count 8, one start.
        s0 = n_start;
        push_tri(8'h11, 0, 3, 0, 1, 8, 1'b1, 1'b1);
        k = 0;
        do begin
            @(posedge clk); #1;
            k++;
        end while (!ras_start && k < 10);
        chk("start_latency", k, 2);
        wait_drain();
        chk("single_start", n_start - s0, 1);

        // Five pushes with the generator busy: queue fills at four, order preserved.
        gen_hold = 1'b1;
        @(posedge clk); #1;
        s0 = n_start;
        push_tri(8'h21, 0, 0, 0, 0, 1, 1'b1, 1'b1);
        push_tri(8'h22, 0, 1, 0, 0, 2, 1'b1, 1'b1);
        push_tri(8'h23, 4, 4, 1, 3, 3, 1'b1, 1'b1);
        push_tri(8'h24, 7, 7, 9, 9, 1, 1'b1, 1'b1);
        chk("queue_full_rdy", tri_rdy, 0);
        chk("held_no_start", ras_start, 0);
        gen_hold = 1'b0;
        push_tri(8'h25, 2, 3, 2, 3, 4, 1'b1, 1'b1);
        wait_drain();
        chk("five_starts", n_start - s0, 5);

        // Degenerate box: retire with count 0 two cycles after acceptance, no start.
        s0 = n_start;
        push_tri(8'h31, 5, 2, 0, 0, 0, 1'b1, 1'b0);
        @(posedge clk); #1;
        chk("degen_cmp_early", cmp_val, 0);
        @(posedge clk); #1;
        chk("degen_cmp_val", cmp_val, 1);
        chk("degen_cmp_cnt", cmp_cnt, 0);
        chk("degen_cmp_id", cmp_id, 8'h31);
        wait_drain();
        chk("degen_no_start", n_start - s0, 0);

        // Consumer stalls every other cycle, then completion held back for 10 cycles.
        s0 = n_start;
        cmp_rdy = 1'b0;
        frag_out_rdy = 1'b0;
        push_tri(8'h41, 0, 1, 0, 1, 4, 1'b1, 1'b1);
        push_tri(8'h42, 3, 3, 2, 2, 1, 1'b1, 1'b1);
        b = 0;
        while (!cmp_val && b < 200) begin
            @(posedge clk); #1;
            frag_out_rdy = ~frag_out_rdy;
            b++;
        end
        chk("stall_cmp_seen", cmp_val, 1);
        repeat (10) begin
            @(posedge clk); #1;
            chk("hold_cmp_val", cmp_val, 1);
            chk("hold_cmp_id", cmp_id, 8'h41);
            chk("hold_cmp_cnt", cmp_cnt, 4);
            chk("hold_no_start", ras_start, 0);
        end
        chk("hold_start_count", n_start - s0, 1);
        cmp_rdy = 1'b1;
        frag_out_rdy = 1'b1;
        wait_drain();
        chk("stall_starts", n_start - s0, 2);

        // Generator never finishes: watchdog flags at RUN cycle 64, then async reset aborts.
        gen_hang = 1'b1;
        frag_out_rdy = 1'b0;
        chk("err_before", err_timeout, 0);
        push_tri(8'h51, 0, 0, 0, 0, 0, 1'b0, 1'b1);
        b = 0;
        while (!ras_start && b < 20) begin
            @(posedge clk); #1;
            b++;
        end
        chk("hang_started", ras_start, 1);
        repeat (63) @(posedge clk);
        #1 chk("err_at_63", err_timeout, 0);
        @(posedge clk); #1;
        chk("err_at_64", err_timeout, 1);
        repeat (5) @(posedge clk);
        #1;
        chk("err_sticky", err_timeout, 1);
        chk("still_run", state_dbg, 2);
        chk("frag_val_in_run", frag_out_val, 1);
        #3 rst = 1'b1;
        #1;
        chk("arst_err", err_timeout, 0);
        chk("arst_start", ras_start, 0);
        chk("arst_cmp_val", cmp_val, 0);
        chk("arst_frag_val", frag_out_val, 0);
        chk("arst_cnt", cmp_cnt, 0);
        chk("arst_state", state_dbg, 0);
        chk("arst_tri_rdy", tri_rdy, 1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        gen_hang = 1'b0;
        frag_out_rdy = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        push_tri(8'h61, 0, 1, 5, 5, 2, 1'b1, 1'b1);
        wait_drain();
        chk("recover_err", err_timeout, 0);
        chk("desc_q_empty", exp_desc_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #400000;
        n_err++;
        $display("FAIL global_timeout: got running expected finished");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $fatal(1, "bench time limit");
    end
endmodule
